// File: rtl/ofdm_tx_byte_buffer_pkg.sv
// Shared OFDM definitions: modulation codes, bytes-per-symbol table and
// the byte-buffer FSM state encoding.
package ofdm_tx_byte_buffer_pkg;

  localparam logic [2:0] MOD_BPSK  = 3'd0;
  localparam logic [2:0] MOD_QPSK  = 3'd1;
  localparam logic [2:0] MOD_QAM16 = 3'd2;
  localparam logic [2:0] MOD_QAM64 = 3'd3;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_STREAM    = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Unknown codes fall back to the BPSK rate.
  function automatic logic [7:0] bytes_per_symbol(input logic [2:0] modulation);
    case (modulation)
      MOD_QPSK:  return 8'd48;
      MOD_QAM16: return 8'd96;
      MOD_QAM64: return 8'd144;
      default:   return 8'd24;
    endcase
  endfunction

endpackage

// File: rtl/ofdm_byte_fifo.sv
// Simple dual-port byte FIFO with registered read; storage is left
// unreset so it maps onto block RAM.
module ofdm_byte_fifo #(
  parameter int MEM_AW = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic [MEM_AW:0]   level,
  output logic              full
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [7:0]        mem [DEPTH];
  logic [MEM_AW-1:0] wr_ptr;
  logic [MEM_AW-1:0] rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // level never exceeds DEPTH, so its MSB alone marks full.
  assign full  = level[MEM_AW];
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && (level != '0);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
    if (do_rd) rd_data <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ofdm_tx_byte_buffer.sv
// Buffers host payload bytes and releases one whole frame at a time to the
// OFDM symbol generator once enough bytes are stored.
module ofdm_tx_byte_buffer
  import ofdm_tx_byte_buffer_pkg::*;
#(
  parameter int MEM_AW = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_valid,
  input  logic [7:0]      wr_data,
  output logic            wr_ready,
  input  logic [7:0]      frame_size,
  input  logic [2:0]      modulation,
  input  logic            gen_ready,
  input  logic            gen_done,
  output logic            begin_tx,
  output logic            out_valid,
  output logic [7:0]      out_data,
  output logic [7:0]      out_frame_size,
  output logic [2:0]      out_modulation,
  output logic [MEM_AW:0] fifo_level,
  output logic            busy,
  output logic            err_oversize,
  output logic [1:0]      state
);

  // Handshake: a host byte is taken on any rising edge where wr_valid and
  // wr_ready are both high; out_valid has no back-pressure and is gated by
  // gen_ready one cycle earlier, when the byte is popped.

  localparam int DEPTH = 1 << MEM_AW;

  logic [15:0] frame_bytes;
  logic [15:0] remaining;
  logic        oversize;
  logic        idle_oversize;
  logic        oversize_q;
  logic        can_start;
  logic        pop;
  logic        full;
  logic [7:0]  fifo_rd_data;

  assign frame_bytes   = 16'(frame_size) * 16'(bytes_per_symbol(modulation));
  assign oversize      = (frame_size != 8'd0) && ({1'b0, frame_bytes} > 17'(DEPTH));
  assign idle_oversize = (state == ST_IDLE) && oversize;
  assign can_start     = (frame_size != 8'd0) && !oversize &&
                         (17'(fifo_level) >= {1'b0, frame_bytes});
  assign pop           = (state == ST_STREAM) && gen_ready && (remaining != 16'd0);

  assign wr_ready = !full;
  assign begin_tx = (state == ST_START);
  assign busy     = (state != ST_IDLE);
  // The RAM read register is unreset; gating keeps out_data clean outside valid cycles.
  assign out_data = out_valid ? fifo_rd_data : 8'd0;

  ofdm_byte_fifo #(.MEM_AW(MEM_AW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      remaining      <= 16'd0;
      out_valid      <= 1'b0;
      out_frame_size <= 8'd0;
      out_modulation <= 3'd0;
      oversize_q     <= 1'b0;
      err_oversize   <= 1'b0;
    end else begin
      out_valid    <= pop;
      oversize_q   <= idle_oversize;
      // Pulse once per oversize request rather than every cycle it is held.
      err_oversize <= idle_oversize && !oversize_q;
      case (state)
        ST_IDLE: begin
          if (can_start) begin
            out_frame_size <= frame_size;
            out_modulation <= modulation;
            remaining      <= frame_bytes;
            state          <= ST_START;
          end
        end
        ST_START: state <= ST_STREAM;
        ST_STREAM: begin
          if (remaining == 16'd0) state <= ST_WAIT_DONE;
          else if (pop) remaining <= remaining - 16'd1;
        end
        ST_WAIT_DONE: begin
          if (gen_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofdm_tx_byte_buffer.sv
// Directed self-checking bench for ofdm_tx_byte_buffer.
module tb_ofdm_tx_byte_buffer;

  localparam int MEM_AW = 11;

  logic            clk;
  logic            reset;
  logic            wr_valid;
  logic [7:0]      wr_data;
  logic            wr_ready;
  logic [7:0]      frame_size;
  logic [2:0]      modulation;
  logic            gen_ready;
  logic            gen_done;
  logic            begin_tx;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [7:0]      out_frame_size;
  logic [2:0]      out_modulation;
  logic [MEM_AW:0] fifo_level;
  logic            busy;
  logic            err_oversize;
  logic [1:0]      state;

  int n_tests = 0;
  int n_fail  = 0;
  int begin_cnt = 0;
  int err_cnt   = 0;
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];

  ofdm_tx_byte_buffer #(.MEM_AW(MEM_AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .frame_size     (frame_size),
    .modulation     (modulation),
    .gen_ready      (gen_ready),
    .gen_done       (gen_done),
    .begin_tx       (begin_tx),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_frame_size (out_frame_size),
    .out_modulation (out_modulation),
    .fifo_level     (fifo_level),
    .busy           (busy),
    .err_oversize   (err_oversize),
    .state          (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid) cap_q.push_back(out_data);
      if (begin_tx) begin_cnt++;
      if (err_oversize) err_cnt++;
    end
  end

  // Driver tasks
  task automatic write_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = first + 8'(i);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] target, input int budget, input string name);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state === target) begin
        got = 1;
        break;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s: state %0d, required %0d within %0d cycles", name, state, target, budget);
    end
  endtask

  task automatic finish_frame(input string name);
    frame_size = 8'd0;
    gen_done   = 1'b1;
    @(negedge clk);
    gen_done   = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy %b, required 0", name, busy);
    end
  endtask

  task automatic compare_stream(input string name);
    n_tests++;
    if (cap_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: %0d bytes, required %0d", name, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_tests++;
      if (cap_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_byte%0d: %0d, required %0d", name, i, cap_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: %b, required 1", wr_ready); end
    n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL rst_level: %0d, required 0", fifo_level); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b, required 0", busy); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state: %0d, required 0", state); end
    n_tests++;
    if ({begin_tx, out_valid, err_oversize, out_data, out_frame_size, out_modulation} !== '0) begin
      n_fail++;
      $display("FAIL rst_outputs: begin %b valid %b err %b data %0d fs %0d mod %0d, required all 0",
               begin_tx, out_valid, err_oversize, out_data, out_frame_size, out_modulation);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    modulation = 3'd0;
    gen_ready  = 1'b1;
    write_seq(8'd0, 48);
    n_tests++; if (fifo_level !== 12'd48) begin n_fail++; $display("FAIL basic_fill: level %0d, required 48", fifo_level); end
    cap_q.delete(); exp_q.delete(); begin_cnt = 0;
    for (int i = 0; i < 48; i++) exp_q.push_back(8'(i));
    frame_size = 8'd2;
    wait_state(2'd3, 200, "basic_wait_done");
    n_tests++; if (begin_cnt != 1) begin n_fail++; $display("FAIL basic_begin: %0d pulses, required 1", begin_cnt); end
    compare_stream("basic");
    n_tests++; if (fifo_level !== '0) begin n_fail++; $display("FAIL basic_level: %0d, required 0", fifo_level); end
    n_tests++; if (out_frame_size !== 8'd2) begin n_fail++; $display("FAIL basic_fs: %0d, required 2", out_frame_size); end
    finish_frame("basic");
  endtask

  task automatic test_threshold();
    int got;
    cap_q.delete(); exp_q.delete(); begin_cnt = 0;
    for (int i = 0; i < 144; i++) exp_q.push_back(8'(100 + i));
    modulation = 3'd3;
    frame_size = 8'd1;
    gen_ready  = 1'b1;
    write_seq(8'd100, 100);
    repeat (5) @(negedge clk);
    n_tests++; if (begin_cnt != 0) begin n_fail++; $display("FAIL thr_early_begin: %0d pulses, required 0", begin_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL thr_early_busy: %b, required 0", busy); end
    write_seq(8'd200, 44);
    got = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (begin_tx === 1'b1) got = 1;
    end
    n_tests++; if (!got) begin n_fail++; $display("FAIL thr_begin: no begin_tx within 2 cycles, required 1"); end
    wait_state(2'd3, 400, "thr_wait_done");
    compare_stream("thr");
    n_tests++; if (out_modulation !== 3'd3) begin n_fail++; $display("FAIL thr_mod: %0d, required 3", out_modulation); end
    n_tests++; if (out_frame_size !== 8'd1) begin n_fail++; $display("FAIL thr_fs: %0d, required 1", out_frame_size); end
    finish_frame("thr");
  endtask

  task automatic test_toggle_ready();
    int got;
    cap_q.delete(); exp_q.delete(); begin_cnt = 0;
    for (int i = 0; i < 48; i++) exp_q.push_back(8'(8'h40 + i));
    modulation = 3'd1;
    gen_ready  = 1'b0;
    write_seq(8'h40, 48);
    frame_size = 8'd1;
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      gen_ready = ~gen_ready;
      if (state === 2'd3) begin
        got = 1;
        break;
      end
    end
    gen_ready = 1'b0;
    n_tests++; if (!got) begin n_fail++; $display("FAIL tog_wait_done: state %0d, required 3", state); end
    n_tests++; if (begin_cnt != 1) begin n_fail++; $display("FAIL tog_begin: %0d pulses, required 1", begin_cnt); end
    compare_stream("tog");
    finish_frame("tog");
  endtask

  task automatic test_oversize();
    begin_cnt = 0; err_cnt = 0;
    modulation = 3'd3;
    frame_size = 8'd15;
    repeat (10) @(negedge clk);
    n_tests++; if (err_cnt != 1) begin n_fail++; $display("FAIL ovs_err: %0d pulse cycles, required 1", err_cnt); end
    n_tests++; if (begin_cnt != 0) begin n_fail++; $display("FAIL ovs_begin: %0d pulses, required 0", begin_cnt); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ovs_busy: %b, required 0", busy); end
    frame_size = 8'd0;
    @(negedge clk);
  endtask

  task automatic test_full();
    modulation = 3'd0;
    frame_size = 8'd0;
    gen_ready  = 1'b0;
    write_seq(8'd0, 2048);
    n_tests++; if (fifo_level !== 12'd2048) begin n_fail++; $display("FAIL full_level: %0d, required 2048", fifo_level); end
    n_tests++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: %b, required 0", wr_ready); end
    write_seq(8'hAA, 1);
    n_tests++; if (fifo_level !== 12'd2048) begin n_fail++; $display("FAIL full_drop: level %0d, required 2048", fifo_level); end
    frame_size = 8'd1;
    wait_state(2'd2, 10, "full_stream");
    frame_size = 8'd0;
    gen_ready  = 1'b1;
    @(negedge clk);
    n_tests++; if (fifo_level !== 12'd2047) begin n_fail++; $display("FAIL full_pop: level %0d, required 2047", fifo_level); end
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    @(negedge clk);
    wr_valid  = 1'b0;
    gen_ready = 1'b0;
    n_tests++; if (fifo_level !== 12'd2047) begin n_fail++; $display("FAIL full_push_pop: level %0d, required 2047", fifo_level); end
  endtask

  task automatic test_reset_mid_stream();
    gen_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_streaming: out_valid %b, required 1", out_valid); end
    reset = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin n_fail++; $display("FAIL mid_rst_out: valid %b data %0d, required 0 0", out_valid, out_data); end
    n_tests++; if (busy !== 1'b0 || state !== 2'd0) begin n_fail++; $display("FAIL mid_rst_state: busy %b state %0d, required 0 0", busy, state); end
    n_tests++; if (fifo_level !== '0 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_level: level %0d ready %b, required 0 1", fifo_level, wr_ready); end
    n_tests++; if (out_frame_size !== 8'd0 || begin_tx !== 1'b0) begin n_fail++; $display("FAIL mid_rst_latched: fs %0d begin %b, required 0 0", out_frame_size, begin_tx); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_partial: out_valid %b, required 0", out_valid); end
    n_tests++; if (fifo_level !== '0 || state !== 2'd0) begin n_fail++; $display("FAIL mid_release: level %0d state %0d, required 0 0", fifo_level, state); end
  endtask

  initial begin
    reset      = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 8'd0;
    frame_size = 8'd0;
    modulation = 3'd0;
    gen_ready  = 1'b0;
    gen_done   = 1'b0;
    test_reset();
    test_basic_frame();
    test_threshold();
    test_toggle_ready();
    test_oversize();
    test_full();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ofdm_tx_byte_buffer.md
OFDM_TX_BYTE_BUFFER -- requirements
Module: ofdm_tx_byte_buffer

Interface
REQ-001 SHALL have parameter MEM_AW, default 11, meaning log2 of the byte FIFO depth (2048).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port wr_valid, input, 1, host byte strobe.
REQ-005 SHALL have port wr_data, input, 8, host payload byte.
REQ-006 SHALL have port wr_ready, output, 1, high when the FIFO is not full.
REQ-007 SHALL have port frame_size, input, 8, number of data symbols per frame.
REQ-008 SHALL have port modulation, input, 3, data modulation code (shared BPSK/QPSK/QAM16/QAM64 codes).
REQ-009 SHALL have port gen_ready, input, 1, downstream generator's flag_ready_read.
REQ-010 SHALL have port gen_done, input, 1, downstream generator's done_transmit.
REQ-011 SHALL have port begin_tx, output, 1, one-cycle frame start pulse to the generator.
REQ-012 SHALL have port out_valid, output, 1, payload byte strobe to the generator.
REQ-013 SHALL have port out_data, output, 8, payload byte.
REQ-014 SHALL have port out_frame_size, output, 8, latched frame_size.
REQ-015 SHALL have port out_modulation, output, 3, latched modulation.
REQ-016 SHALL have port fifo_level, output, MEM_AW+1, bytes stored.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port err_oversize, output, 1, one-cycle pulse when a frame cannot fit in the FIFO.

Function
REQ-019 SHALL derive bytes per symbol from modulation: BPSK 24, QPSK 48, QAM16 96, QAM64 144; any other code is treated as BPSK.
REQ-020 SHALL compute frame_bytes = frame_size * bytes_per_symbol, unsigned, 16 bits.
REQ-021 SHALL write wr_data when wr_valid && wr_ready; a write while full is dropped and the level is unchanged.
REQ-022 SHALL leave fifo_level unchanged on a simultaneous write and read; pointers SHALL wrap modulo 2^MEM_AW.
REQ-023 SHALL implement the FSM IDLE -> START -> STREAM -> WAIT_DONE -> IDLE.
REQ-024 IDLE: if frame_size != 0 and frame_bytes > 2^MEM_AW, SHALL pulse err_oversize and stay in IDLE.
REQ-025 IDLE: if frame_size != 0 and fifo_level >= frame_bytes, SHALL latch frame_size, modulation and frame_bytes into remaining, then go to START; frame_size == 0 never starts.
REQ-026 START: SHALL assert begin_tx for exactly one cycle, then go to STREAM.
REQ-027 STREAM: each cycle with gen_ready high and remaining > 0 SHALL pop one byte and decrement remaining.
REQ-028 A popped byte SHALL appear on out_data with out_valid high in the next cycle; out_valid SHALL be low at all other times.
REQ-029 STREAM SHALL go to WAIT_DONE in the cycle after remaining reaches 0.
REQ-030 WAIT_DONE: SHALL go to IDLE when gen_done is high; bytes written meanwhile are retained.
REQ-031 out_frame_size and out_modulation SHALL be latched values and stay stable from START until the next start.
REQ-032 Host writes SHALL be accepted in every state, including STREAM.

Reset
REQ-033 While reset is low, SHALL force state IDLE, pointers 0, fifo_level 0, remaining 0, and begin_tx, out_valid, err_oversize, busy, out_data, out_frame_size, out_modulation all 0; wr_ready SHALL be 1.
REQ-034 Reset asserted mid-frame SHALL discard buffered data without emitting a partial byte on the following cycle.

Structure
REQ-035 Modulation codes and the bytes-per-symbol table SHALL live in the shared OFDM package/header alongside the existing modulation defines.
REQ-036 Storage SHALL be a sub-module ofdm_byte_fifo: simple dual-port, registered read, parameterised by MEM_AW, inferring block RAM.

Verification
REQ-037 Write 48 bytes 0..47, frame_size=2, BPSK, gen_ready=1 -> one begin_tx pulse; 48 out_valid cycles carrying 0..47 in order; fifo_level ends at 0.
REQ-038 frame_size=1, QAM64, only 100 bytes written -> no begin_tx; writing 44 more -> begin_tx within 2 cycles.
REQ-039 Toggle gen_ready 1/0 every cycle during STREAM -> byte order is preserved, no duplicates, and the out_valid count equals frame_bytes.
REQ-040 MEM_AW=11, frame_size=15, QAM64 (2160 bytes) -> err_oversize pulse and no begin_tx.
REQ-041 Fill to 2048 bytes -> wr_ready=0 and an extra write is dropped; a simultaneous push and pop keeps the level constant.
REQ-042 Assert reset during STREAM -> all outputs return to reset values immediately; after release, fifo_level=0 and state is IDLE.
